// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default width, flag indices.
// Flag indices follow the {N,Z,C,V} ordering used by the main ALU.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shl  = {rem, quo[WIDTH-1]};
  assign diff = shl - {1'b0, dvs};
  // rem < dvs keeps shl - dvs below 2^WIDTH, so the top bit is a clean borrow
  assign fits = ~diff[WIDTH];

  assign rem_nx = fits ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/alu_div.sv
// Iterative restoring divider for UDIV/SDIV with a Start/Busy/Done handshake.
// Produces quotient, remainder and {N,Z,C,V} flags, all registered.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [3:0]       ALUFlags,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state;
  div_state_e state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] a_q;
  logic             q_neg;
  logic             r_neg;
  logic             ovf;
  logic             dz;

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [3:0]       flags_fin;

  logic accept;
  logic calc;
  logic fin;
  logic dz_fire;

  assign a_mag = (Signed && A[WIDTH-1]) ? -A : A;
  assign b_mag = (Signed && B[WIDTH-1]) ? -B : B;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nx = (B == '0) ? DONE : CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nx = FIN;
        end
      end
      FIN: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy    = 1'b0;
    accept  = 1'b0;
    calc    = 1'b0;
    fin     = 1'b0;
    dz_fire = 1'b0;
    unique case (state)
      IDLE: accept = Start;
      CALC: begin
        Busy = 1'b1;
        calc = 1'b1;
      end
      FIN: fin = 1'b1;
      DONE: begin
        accept  = Start;
        dz_fire = dz;
      end
      default: ;
    endcase
  end

  // Dividend magnitude seeds the quotient register and shifts out MSB-first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      a_q   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else if (accept) begin
      cnt   <= CW'(WIDTH-1);
      rem_q <= '0;
      quo_q <= a_mag;
      dvs_q <= b_mag;
      a_q   <= A;
      q_neg <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      r_neg <= Signed & A[WIDTH-1];
      ovf   <= Signed && (A == MIN) && (B == '1);
      dz    <= (B == '0);
    end else if (calc) begin
      cnt   <= cnt - CW'(1);
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  assign q_fix = q_neg ? -quo_q : quo_q;
  assign r_fix = r_neg ? -rem_q : rem_q;

  always_comb begin
    flags_fin         = '0;
    flags_fin[FLAG_N] = q_fix[WIDTH-1];
    flags_fin[FLAG_Z] = (q_fix == '0);
    flags_fin[FLAG_C] = 1'b0;
    flags_fin[FLAG_V] = ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      ALUFlags  <= 4'b0100;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (fin) begin
        Done      <= 1'b1;
        Quotient  <= q_fix;
        Remainder <= r_fix;
        ALUFlags  <= flags_fin;
        DivByZero <= 1'b0;
      end else if (dz_fire) begin
        Done      <= 1'b1;
        Quotient  <= '0;
        Remainder <= a_q;
        ALUFlags  <= 4'b0100;
        DivByZero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// Randomized self-checking bench for alu_div against a plain-arithmetic
// reference model, plus directed corner cases and handshake checks.
module tb_alu_div;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic         Signed;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic [3:0]   ALUFlags;
  logic         DivByZero;

  int nvec = 0;
  int nerr = 0;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  always #5 clk = ~clk;

  alu_div #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Signed    (Signed),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .ALUFlags  (ALUFlags),
    .DivByZero (DivByZero)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic [3:0] f, output bit dz);
    longint sa, sb, qq, rr;
    bit v;
    v  = 1'b0;
    dz = (b == 0);
    if (dz) begin
      q = '0;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
      v  = (a == MIN) && (b == 32'hFFFF_FFFF);
    end else begin
      q = a / b;
      r = a % b;
    end
    f = dz ? 4'b0100 : {q[W-1], q == 0, 1'b0, v};
  endtask

  task automatic launch(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    Start  = 1'b1;
    Signed = s;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int poke);
    logic [W-1:0] eq, er;
    logic [3:0]   ef;
    bit           ed;
    int           n, busy_n;
    bit           got;
    model(s, a, b, eq, er, ef, ed);
    busy_n = Busy ? 1 : 0;
    n      = 0;
    got    = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (Start) Start = 1'b0;
      if (Done) got = 1'b1;
      else if (Busy) busy_n++;
      if (n == poke) begin
        Start  = 1'b1;
        Signed = ~s;
        A      = $urandom;
        B      = $urandom;
      end
    end
    chk({tag, ".done"}, got, 1);
    chk({tag, ".lat"}, n, ed ? 1 : W + 1);
    chk({tag, ".busy"}, busy_n, ed ? 0 : W);
    chk({tag, ".q"}, Quotient, eq);
    chk({tag, ".r"}, Remainder, er);
    chk({tag, ".flags"}, ALUFlags, ef);
    chk({tag, ".dbz"}, DivByZero, ed);
    last_q = eq;
    last_r = er;
  endtask

  task automatic hold();
    @(posedge clk);
    #1;
    chk("hold.done", Done, 0);
    chk("hold.q", Quotient, last_q);
    chk("hold.r", Remainder, last_r);
  endtask

  initial begin
    bit           s;
    logic [W-1:0] a, b;
    int           poke, sel, seen;

    reset  = 1'b1;
    Start  = 1'b0;
    Signed = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", Busy, 0);
    chk("rst.done", Done, 0);
    chk("rst.q", Quotient, 0);
    chk("rst.r", Remainder, 0);
    chk("rst.flags", ALUFlags, 4'b0100);
    chk("rst.dbz", DivByZero, 0);
    reset = 1'b0;

    launch(0, 100, 7);
    wait_done("udiv", 0, 100, 7, -1);
    hold();
    launch(1, 32'hFFFF_FF9C, 7);
    wait_done("sdiv", 1, 32'hFFFF_FF9C, 7, 5);
    hold();
    launch(0, 32'h1234, 0);
    wait_done("dz", 0, 32'h1234, 0, -1);
    hold();
    launch(1, MIN, 32'hFFFF_FFFF);
    wait_done("sovf", 1, MIN, 32'hFFFF_FFFF, -1);
    launch(0, MIN, 32'hFFFF_FFFF);
    wait_done("uovf", 0, MIN, 32'hFFFF_FFFF, 12);
    launch(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done("chain", 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1);
    hold();

    launch(0, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst.busy", Busy, 0);
    chk("arst.done", Done, 0);
    chk("arst.q", Quotient, 0);
    chk("arst.r", Remainder, 0);
    chk("arst.flags", ALUFlags, 4'b0100);
    chk("arst.dbz", DivByZero, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen  = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (Done) seen = 1;
    end
    chk("arst.nodone", seen, 0);
    last_q = '0;
    last_r = '0;

    for (int i = 0; i < 40; i++) begin
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      a   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      b   = $urandom;
      if (sel == 0) b = '0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) begin
        a = MIN;
        b = 32'hFFFF_FFFF;
      end else if (sel == 3) b = -32'($urandom_range(1, 20));
      poke = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : -1;
      if ($urandom_range(0, 1) == 1) hold();
      launch(s, a, b);
      wait_done("rand", s, a, b, poke);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
